// File: rtl/versatile_fifo_sync_mc.sv
// versatile_fifo_sync_mc: single-clock multi-queue FIFO.
// 2**nr_of_queues_log2 queues share one simple-dual-port RAM. Each queue
// owns a fixed 2**addr_width-word region addressed as {queue, ptr_low}.
// Per-queue flags are decoded from the registered pointers only.
module versatile_fifo_sync_mc #(
    parameter int data_width        = 18,
    parameter int addr_width        = 4,
    parameter int nr_of_queues_log2 = 2,
    parameter int afull_lvl         = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [data_width-1:0]             d,
    input  logic                              wr,
    input  logic [nr_of_queues_log2-1:0]      wr_q,
    input  logic                              rd,
    input  logic [nr_of_queues_log2-1:0]      rd_q,
    output logic [data_width-1:0]             q,
    output logic                              q_valid,
    input  logic [2**nr_of_queues_log2-1:0]   flush,
    output logic [2**nr_of_queues_log2-1:0]   fifo_full,
    output logic [2**nr_of_queues_log2-1:0]   fifo_empty,
    output logic [2**nr_of_queues_log2-1:0]   fifo_afull,
    output logic                              wr_err,
    output logic                              rd_err
);

    localparam int n_q   = 2 ** nr_of_queues_log2;
    localparam int depth = 2 ** addr_width;
    localparam int pw    = addr_width + 1;
    localparam int ram_aw = nr_of_queues_log2 + addr_width;

    // pointer MSB is the wrap bit, so full and empty are distinguishable
    logic [pw-1:0]          wptr [n_q];
    logic [pw-1:0]          rptr [n_q];
    logic [pw-1:0]          cnt  [n_q];
    logic [data_width-1:0]  mem  [n_q*depth];

    logic                   wr_ok;
    logic                   rd_ok;
    logic                   wr_rej;
    logic                   rd_rej;
    logic [ram_aw-1:0]      wr_addr;
    logic [ram_aw-1:0]      rd_addr;

    // decode per-queue status flags from the registered pointers
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        fifo_afull = '0;
        for (int i = 0; i < n_q; i++) begin
            cnt[i]        = wptr[i] - rptr[i];
            fifo_empty[i] = (wptr[i] == rptr[i]);
            fifo_full[i]  = (wptr[i][addr_width-1:0] == rptr[i][addr_width-1:0]) &&
                            (wptr[i][addr_width] != rptr[i][addr_width]);
            fifo_afull[i] = (cnt[i] >= pw'(afull_lvl));
        end
    end

    // accept/reject decisions use pre-edge flags; a flushed queue drops requests silently
    always_comb begin
        wr_ok   = wr && !fifo_full[wr_q] && !flush[wr_q];
        rd_ok   = rd && !fifo_empty[rd_q] && !flush[rd_q];
        wr_rej  = wr && fifo_full[wr_q] && !flush[wr_q];
        rd_rej  = rd && fifo_empty[rd_q] && !flush[rd_q];
        wr_addr = {wr_q, wptr[wr_q][addr_width-1:0]};
        rd_addr = {rd_q, rptr[rd_q][addr_width-1:0]};
    end

    // pointer update: write advances wptr, flush snaps rptr onto wptr, else read advances rptr
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < n_q; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < n_q; i++) begin
                if (wr_ok && (wr_q == nr_of_queues_log2'(i)))
                    wptr[i] <= wptr[i] + pw'(1);
                if (flush[i])
                    rptr[i] <= wptr[i];
                else if (rd_ok && (rd_q == nr_of_queues_log2'(i)))
                    rptr[i] <= rptr[i] + pw'(1);
            end
        end
    end

    // shared RAM write port; contents are never reset or cleared
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wr_addr] <= d;
    end

    // registered read data, valid flag and one-cycle error strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
            wr_err  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            q_valid <= rd_ok;
            wr_err  <= wr_rej;
            rd_err  <= rd_rej;
            if (rd_ok)
                q <= mem[rd_addr];
        end
    end

endmodule
